// File: rtl/mem_stage_dmem.sv
// mem_stage_dmem: MEM-stage data memory responder plus MEM/WB pipeline register.
//
// Owns a word-addressed data RAM and services load/store requests arriving from the
// EX/MEM register. Each access takes LATENCY wait states, during which mem_stall_o holds
// the upstream pipeline. MEM/WB captures the commit result, or a bubble while stalled.
//
// Parameters:
//   ad_size  address width (bits)
//   d_size   data word width (bits)
//   DEPTH    RAM depth in words (power of 2)
//   LATENCY  wait states per access (0 = single-cycle)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           synchronous reset, active low
//   dm_regwrite_i    EX/MEM register write-back enable
//   dm_memtoreg_i    EX/MEM write-back selects memory data
//   dm_mem_write_i   EX/MEM store request
//   dm_memread_i     EX/MEM load request
//   dm_rd_i          EX/MEM destination register
//   mem_address_i    effective byte address, also forwarded as ALU result
//   dm_data_input_i  store data
//   mem_stall_o      hold PC/IF/ID/ID-EX/EX-MEM this cycle
//   wb_regwrite_o    MEM/WB register write enable
//   wb_memtoreg_o    MEM/WB select wb_read_data_o
//   wb_rd_o          MEM/WB destination register
//   wb_read_data_o   MEM/WB load data
//   wb_alu_result_o  MEM/WB mem_address_i passed through (low d_size bits)
//   mem_err_o        misaligned access flag
//
// Configuration macro MISALIGN_TRAP_EN: when defined, an access with a non-zero byte
// offset commits immediately, suppresses the store, returns 0, clears wb_regwrite and
// pulses mem_err_o for one cycle. When undefined, the byte offset is ignored and
// mem_err_o is tied low.

module mem_stage_dmem #(
  parameter int unsigned ad_size = 32,
  parameter int unsigned d_size  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dm_regwrite_i,
  input  logic               dm_memtoreg_i,
  input  logic               dm_mem_write_i,
  input  logic               dm_memread_i,
  input  logic [4:0]         dm_rd_i,
  input  logic [ad_size-1:0] mem_address_i,
  input  logic [d_size-1:0]  dm_data_input_i,
  output logic               mem_stall_o,
  output logic               wb_regwrite_o,
  output logic               wb_memtoreg_o,
  output logic [4:0]         wb_rd_o,
  output logic [d_size-1:0]  wb_read_data_o,
  output logic [d_size-1:0]  wb_alu_result_o,
  output logic               mem_err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              access;
  logic              misalign;
  logic              commit;
  logic [IdxW-1:0]   idx;
  logic [d_size-1:0] load_data;

  logic              wb_regwrite_q;
  logic              wb_memtoreg_q;
  logic [4:0]        wb_rd_q;
  logic [d_size-1:0] wb_read_data_q;
  logic [d_size-1:0] wb_alu_result_q;

  logic [d_size-1:0] ram_q [DEPTH];

  assign access = dm_memread_i | dm_mem_write_i;
  // Upper address bits are dropped, so accesses wrap modulo DEPTH words.
  assign idx    = mem_address_i[IdxW+1:2];

`ifdef MISALIGN_TRAP_EN
  assign misalign = access & (mem_address_i[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_stall_o = 1'b0;
    commit      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          // Misaligned traps never wait: nothing is read or written.
          if (LATENCY == 0 || misalign) begin
            commit = 1'b1;
          end else begin
            mem_stall_o = 1'b1;
            cnt_d       = CntW'(1);
            state_d     = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == CntW'(LATENCY)) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          mem_stall_o = 1'b1;
          cnt_d       = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Store wins over a simultaneous load, which then returns 0. Reading the array here
  // gives the pre-write value on a same-edge store.
  assign load_data = (commit && dm_memread_i && !dm_mem_write_i && !misalign) ?
                     ram_q[idx] : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      wb_regwrite_q   <= 1'b0;
      wb_memtoreg_q   <= 1'b0;
      wb_rd_q         <= '0;
      wb_read_data_q  <= '0;
      wb_alu_result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (mem_stall_o) begin
        // Bubble: kill write-back controls, leave the data fields alone.
        wb_regwrite_q <= 1'b0;
        wb_memtoreg_q <= 1'b0;
      end else begin
        wb_regwrite_q   <= dm_regwrite_i & ~misalign;
        wb_memtoreg_q   <= dm_memtoreg_i;
        wb_rd_q         <= dm_rd_i;
        wb_read_data_q  <= load_data;
        wb_alu_result_q <= d_size'(mem_address_i);
      end
    end
  end

  // RAM is never cleared; a reset edge blocks any commit.
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && dm_mem_write_i && !misalign) begin
      ram_q[idx] <= dm_data_input_i;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mem_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= commit & misalign;
    end
  end

  assign mem_err_o = mem_err_q;
`else
  assign mem_err_o = 1'b0;
`endif

  assign wb_regwrite_o   = wb_regwrite_q;
  assign wb_memtoreg_o   = wb_memtoreg_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_read_data_o  = wb_read_data_q;
  assign wb_alu_result_o = wb_alu_result_q;

endmodule
